// File: rtl/wrp_shff_txgen.sv
// ---------------------------------------------------------------------------
// wrp_shff_txgen
//
// Test-pattern frame generator that feeds the shuffle stage over AXI-Stream.
// A run begins on a start pulse. It emits frames of FRM_LEN samples, with
// GAP idle cycles between frames, until nfrm frames are done or a stop
// request is honoured at a frame boundary. nfrm = 0 means the run is
// continuous.
//
// Output word layout:
//   [63:60] LANE   [59:48] zero   [47:32] frame index   [31:0] sample index
//
// Ports
//   dat_clk       in   1   clock; all logic is on posedge
//   dat_resetn    in   1   asynchronous active-low reset
//   start         in   1   one-cycle pulse; begins a run (honoured in IDLE only)
//   stop          in   1   one-cycle pulse; ends the run at the next frame boundary
//   nfrm          in  16   frames per run, sampled on an accepted start
//   out_axi_trdy  in   1   AXIS TREADY
//   out_axi_tvld  out  1   AXIS TVALID
//   out_axi_tdat  out 64   AXIS TDATA
//   out_axi_tlst  out  1   AXIS TLAST, high on the last sample of each frame
//   busy          out  1   high whenever the FSM is not idle
//   done          out  1   one-cycle pulse after a run ends
//   frm_cnt       out 16   frames completed since the last accepted start
// ---------------------------------------------------------------------------
module wrp_shff_txgen #(
    parameter logic [3:0]  LANE    = 4'd0,
    parameter logic [31:0] FRM_LEN = 32'd1024,
    parameter logic [7:0]  GAP     = 8'd0
) (
    input  logic        dat_clk,
    input  logic        dat_resetn,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] nfrm,
    input  logic        out_axi_trdy,
    output logic        out_axi_tvld,
    output logic [63:0] out_axi_tdat,
    output logic        out_axi_tlst,
    output logic        busy,
    output logic        done,
    output logic [15:0] frm_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StGap  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] samp_q, samp_d;
    // The frame index and the completed-frame count are cleared and advanced
    // together, so a single counter serves as both.
    logic [15:0] frm_q, frm_d;
    logic [15:0] nfrm_q, nfrm_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic        stop_pend_q, stop_pend_d;
    logic        done_q, done_d;

    logic        xfer;
    logic        last_samp;
    logic [15:0] frm_inc;
    logic        run_end;

    // TVALID comes from registered state only, so it never depends on TREADY.
    assign xfer      = (state_q == StRun) && out_axi_trdy;
    assign last_samp = (samp_q == (FRM_LEN - 32'd1));
    assign frm_inc   = frm_q + 16'd1;
    // A stop arriving on the TLAST beat itself also ends the run there.
    assign run_end   = ((nfrm_q != 16'd0) && (frm_inc == nfrm_q)) || stop_pend_q || stop;

    always_comb begin
        state_d     = state_q;
        samp_d      = samp_q;
        frm_d       = frm_q;
        nfrm_d      = nfrm_q;
        gap_cnt_d   = gap_cnt_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;

        case (state_q)
            StIdle: begin
                // stop is ignored here, including when it coincides with start.
                if (start) begin
                    nfrm_d      = nfrm;
                    samp_d      = 32'd0;
                    frm_d       = 16'd0;
                    stop_pend_d = 1'b0;
                    state_d     = StRun;
                end
            end

            StRun: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (xfer) begin
                    if (last_samp) begin
                        samp_d = 32'd0;
                        frm_d  = frm_inc;
                        if (run_end) begin
                            state_d     = StIdle;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                        end else if (GAP == 8'd0) begin
                            state_d = StRun;
                        end else begin
                            // Counts down to zero so that exactly GAP idle
                            // cycles are spent in StGap.
                            state_d   = StGap;
                            gap_cnt_d = GAP - 8'd1;
                        end
                    end else begin
                        samp_d = samp_q + 32'd1;
                    end
                end
            end

            StGap: begin
                if (stop) begin
                    state_d     = StIdle;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q == 8'd0) begin
                    state_d = StRun;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge dat_clk or negedge dat_resetn) begin
        if (!dat_resetn) begin
            state_q     <= StIdle;
            samp_q      <= 32'd0;
            frm_q       <= 16'd0;
            nfrm_q      <= 16'd0;
            gap_cnt_q   <= 8'd0;
            stop_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            frm_q       <= frm_d;
            nfrm_q      <= nfrm_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_pend_q <= stop_pend_d;
            done_q      <= done_d;
        end
    end

    // The data word is gated with TVALID, so it reads zero outside StRun.
    always_comb begin
        out_axi_tvld = (state_q == StRun);
        out_axi_tlst = out_axi_tvld && last_samp;
        out_axi_tdat = 64'd0;
        if (out_axi_tvld) begin
            out_axi_tdat = {LANE, 12'h000, frm_q, samp_q};
        end
        busy    = (state_q != StIdle);
        done    = done_q;
        frm_cnt = frm_q;
    end

endmodule

// File: tb/tb_wrp_shff_txgen.sv
// ---------------------------------------------------------------------------
// tb_wrp_shff_txgen
//
// Scoreboarded bench with two generators on a shared clock and reset.
//   u_dut0: FRM_LEN=4, GAP=0, LANE=5
//   u_dut1: FRM_LEN=4, GAP=3, LANE=9
// Expected beats are queued when a run is started. A negedge monitor pops
// them on every accepted transfer. The monitor also checks stall stability,
// the done pulse timing and the inter-frame gap length.
// ---------------------------------------------------------------------------
module tb_wrp_shff_txgen;

    localparam int FL = 4;

    typedef struct {
        logic [63:0] dat;
        logic        lst;
        logic        dn;
    } beat_t;

    logic        dat_clk;
    logic        dat_resetn;
    logic        stop;
    logic [15:0] nfrm;
    logic        trdy;
    logic        start_w  [2];
    logic        tvld_w   [2];
    logic [63:0] tdat_w   [2];
    logic        tlst_w   [2];
    logic        busy_w   [2];
    logic        done_w   [2];
    logic [15:0] frmcnt_w [2];

    beat_t q0[$];
    beat_t q1[$];

    int          n_chk;
    int          n_fail;
    logic        exp_dn   [2];
    logic        stalled  [2];
    logic [63:0] hold_dat [2];
    logic        hold_lst [2];
    int          beats    [2];
    int          idle_run [2];
    logic        tog_en;

    wrp_shff_txgen #(
        .LANE    (4'd5),
        .FRM_LEN (32'd4),
        .GAP     (8'd0)
    ) u_dut0 (
        .dat_clk      (dat_clk),
        .dat_resetn   (dat_resetn),
        .start        (start_w[0]),
        .stop         (stop),
        .nfrm         (nfrm),
        .out_axi_trdy (trdy),
        .out_axi_tvld (tvld_w[0]),
        .out_axi_tdat (tdat_w[0]),
        .out_axi_tlst (tlst_w[0]),
        .busy         (busy_w[0]),
        .done         (done_w[0]),
        .frm_cnt      (frmcnt_w[0])
    );

    wrp_shff_txgen #(
        .LANE    (4'd9),
        .FRM_LEN (32'd4),
        .GAP     (8'd3)
    ) u_dut1 (
        .dat_clk      (dat_clk),
        .dat_resetn   (dat_resetn),
        .start        (start_w[1]),
        .stop         (stop),
        .nfrm         (nfrm),
        .out_axi_trdy (trdy),
        .out_axi_tvld (tvld_w[1]),
        .out_axi_tdat (tdat_w[1]),
        .out_axi_tlst (tlst_w[1]),
        .busy         (busy_w[1]),
        .done         (done_w[1]),
        .frm_cnt      (frmcnt_w[1])
    );

    initial begin
        dat_clk = 1'b0;
        forever #5 dat_clk = ~dat_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic push(input int i, input int nf, input bit dn_last);
        beat_t b;
        logic [3:0] lane;
        lane = (i == 0) ? 4'd5 : 4'd9;
        for (int f = 0; f < nf; f++) begin
            for (int s = 0; s < FL; s++) begin
                b.dat = {lane, 12'h000, 16'(f), 32'(s)};
                b.lst = (s == FL - 1);
                b.dn  = dn_last && (f == nf - 1) && (s == FL - 1);
                if (i == 0) q0.push_back(b);
                else q1.push_back(b);
            end
        end
    endtask

    task automatic do_start(input int i, input logic [15:0] n, input logic with_stop);
        @(posedge dat_clk);
        #1;
        nfrm       = n;
        start_w[i] = 1'b1;
        stop       = with_stop;
        beats[i]   = 0;
        idle_run[i] = 0;
        @(posedge dat_clk);
        #1;
        start_w[i] = 1'b0;
        stop       = 1'b0;
        chk("tvld_latency", 64'(tvld_w[i]), 64'd1);
    endtask

    task automatic wait_idle(input int i, input logic [15:0] exp_cnt);
        int   k;
        logic ok;
        ok = 1'b0;
        for (k = 0; k < 2000; k++) begin
            @(negedge dat_clk);
            if (!busy_w[i]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("run_timeout", 64'(!ok), 64'd0);
        repeat (2) @(negedge dat_clk);
        chk("sb_empty", 64'((i == 0) ? q0.size() : q1.size()), 64'd0);
        chk("frm_cnt", 64'(frmcnt_w[i]), 64'(exp_cnt));
    endtask

    task automatic chk_zero(input int i);
        chk("rst_tvld", 64'(tvld_w[i]), 64'd0);
        chk("rst_tlst", 64'(tlst_w[i]), 64'd0);
        chk("rst_tdat", tdat_w[i], 64'd0);
        chk("rst_busy", 64'(busy_w[i]), 64'd0);
        chk("rst_done", 64'(done_w[i]), 64'd0);
        chk("rst_frm_cnt", 64'(frmcnt_w[i]), 64'd0);
    endtask

    // Blocks until dut0 presents the given frame/sample; reports a timeout.
    task automatic wait_beat0(input int f, input int s);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge dat_clk);
            if (tvld_w[0] && tdat_w[0][47:32] == 16'(f) && tdat_w[0][31:0] == 32'(s)) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_beat", 64'(found), 64'd1);
    endtask

    // TREADY driver: constant 1 unless the 1,0,0,1 stall pattern is enabled.
    initial begin
        logic [3:0] pat;
        int         k;
        pat = 4'b1001;
        k   = 0;
        forever begin
            @(posedge dat_clk);
            #1;
            if (tog_en) begin
                trdy = pat[k % 4];
                k    = k + 1;
            end else begin
                trdy = 1'b1;
                k    = 0;
            end
        end
    end

    // Transfer monitor: sampled at negedge, where inputs and outputs are settled.
    initial begin
        beat_t b;
        logic  have;
        forever begin
            @(negedge dat_clk);
            for (int i = 0; i < 2; i++) begin
                if (!dat_resetn) begin
                    exp_dn[i]   = 1'b0;
                    stalled[i]  = 1'b0;
                    idle_run[i] = 0;
                end else begin
                    chk("done_pulse", 64'(done_w[i]), 64'(exp_dn[i]));
                    exp_dn[i] = 1'b0;
                    if (stalled[i]) begin
                        chk("stall_tvld", 64'(tvld_w[i]), 64'd1);
                        chk("stall_tdat", tdat_w[i], hold_dat[i]);
                        chk("stall_tlst", 64'(tlst_w[i]), 64'(hold_lst[i]));
                    end
                    stalled[i]  = tvld_w[i] && !trdy;
                    hold_dat[i] = tdat_w[i];
                    hold_lst[i] = tlst_w[i];
                    if (tvld_w[i] && trdy) begin
                        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                        if (!have) begin
                            chk("beat_extra", tdat_w[i], 64'd0);
                        end else begin
                            if (i == 0) b = q0.pop_front();
                            else b = q1.pop_front();
                            chk("beat_tdat", tdat_w[i], b.dat);
                            chk("beat_tlst", 64'(tlst_w[i]), 64'(b.lst));
                            exp_dn[i] = b.dn;
                        end
                        if (i == 1 && beats[1] == 4) begin
                            chk("gap_len", 64'(idle_run[1]), 64'd3);
                        end
                        beats[i]    = beats[i] + 1;
                        idle_run[i] = 0;
                    end else if (!tvld_w[i]) begin
                        idle_run[i] = idle_run[i] + 1;
                    end
                end
            end
        end
    end

    initial begin
        int seen;
        n_chk  = 0;
        n_fail = 0;
        for (int i = 0; i < 2; i++) begin
            start_w[i]  = 1'b0;
            exp_dn[i]   = 1'b0;
            stalled[i]  = 1'b0;
            hold_dat[i] = 64'd0;
            hold_lst[i] = 1'b0;
            beats[i]    = 0;
            idle_run[i] = 0;
        end
        dat_resetn = 1'b0;
        stop       = 1'b0;
        nfrm       = 16'd0;
        trdy       = 1'b1;
        tog_en     = 1'b0;
        #3;
        chk_zero(0);
        chk_zero(1);
        #19;
        dat_resetn = 1'b1;
        repeat (2) @(negedge dat_clk);

        // Two frames back to back. stop arrives together with start and is
        // dropped; a start while busy is ignored.
        push(0, 2, 1'b1);
        do_start(0, 16'd2, 1'b1);
        repeat (2) @(posedge dat_clk);
        #1;
        chk("busy_run", 64'(busy_w[0]), 64'd1);
        nfrm       = 16'd5;
        start_w[0] = 1'b1;
        @(posedge dat_clk);
        #1;
        start_w[0] = 1'b0;
        wait_idle(0, 16'd2);

        // Same run under the 1,0,0,1 TREADY pattern.
        tog_en = 1'b1;
        push(0, 2, 1'b1);
        do_start(0, 16'd2, 1'b0);
        wait_idle(0, 16'd2);
        tog_en = 1'b0;

        // Three idle cycles between frames.
        push(1, 2, 1'b1);
        do_start(1, 16'd2, 1'b0);
        wait_idle(1, 16'd2);
        chk("gap_beats", 64'(beats[1]), 64'd8);

        // Continuous run, stopped at sample 1 of frame 5.
        push(0, 6, 1'b1);
        do_start(0, 16'd0, 1'b0);
        wait_beat0(5, 1);
        stop = 1'b1;
        @(posedge dat_clk);
        #1;
        stop = 1'b0;
        wait_idle(0, 16'd6);

        // Reset mid-frame at sample 2 of frame 0, then a fresh run.
        push(0, 2, 1'b0);
        do_start(0, 16'd0, 1'b0);
        wait_beat0(0, 2);
        #2;
        dat_resetn = 1'b0;
        #1;
        chk_zero(0);
        q0.delete();
        @(negedge dat_clk);
        #2;
        dat_resetn = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge dat_clk);
            if (tvld_w[0] || busy_w[0]) seen = seen + 1;
        end
        chk("idle_after_reset", 64'(seen), 64'd0);
        push(0, 1, 1'b1);
        do_start(0, 16'd1, 1'b0);
        wait_idle(0, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wrp_shff_txgen.md
WRP_SHFF_TXGEN -- requirements
Module: wrp_shff_txgen

Interface
REQ-001 SHALL have parameter LANE, default 4'd0, lane ID placed in every output word.
REQ-002 SHALL have parameter FRM_LEN, default 32'd1024, samples per frame (legal range >= 1).
REQ-003 SHALL have parameter GAP, default 8'd0, idle cycles inserted between frames.
REQ-004 SHALL have port dat_clk  in  1  single clock; all logic on posedge.
REQ-005 SHALL have port dat_resetn  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse; begins a run.
REQ-007 SHALL have port stop  in  1  one-cycle pulse; ends the run at the next frame boundary.
REQ-008 SHALL have port nfrm  in  16  frames per run, sampled on start; 0 = continuous.
REQ-009 SHALL have port out_axi_trdy  in  1  AXIS TREADY from the shuffle input.
REQ-010 SHALL have port out_axi_tvld  out  1  AXIS TVALID.
REQ-011 SHALL have port out_axi_tdat  out  64  AXIS TDATA.
REQ-012 SHALL have port out_axi_tlst  out  1  AXIS TLAST, high on the last sample of each frame.
REQ-013 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-014 SHALL have port done  out  1  one-cycle pulse at the end of a run.
REQ-015 SHALL have port frm_cnt  out  16  frames completed since the last accepted start.

Function
REQ-016 SHALL implement FSM states IDLE, RUN and GAP, all registered.
REQ-017 Word format SHALL be: [63:60]=LANE, [59:48]=0, [47:32]=frame index, [31:0]=sample index.
REQ-018 In IDLE, start SHALL latch nfrm, clear sample index, frame index and frm_cnt, and enter RUN; tvld SHALL go high the next cycle (latency 1).
REQ-019 In RUN, tvld SHALL be 1; a beat transfers only when tvld and trdy are both 1.
REQ-020 tdat and tlst SHALL hold stable while tvld=1 and trdy=0; tvld SHALL NOT depend combinationally on trdy.
REQ-021 The sample index SHALL increment per transfer; tlst SHALL be 1 exactly when sample index = FRM_LEN-1.
REQ-022 On a tlst transfer: sample index SHALL be set to 0, frame index (wraps at 16 bits) and frm_cnt SHALL increment, and the next state SHALL be chosen as follows:
  - end of run (nfrm != 0 and frm_cnt+1 = nfrm, or stop pending) -> IDLE, with done=1 the following cycle;
  - else GAP=0 -> stay in RUN, back-to-back, no bubble;
  - else -> GAP, with tvld=0 for exactly GAP cycles, then RUN.
REQ-023 A stop in RUN SHALL set stop-pending; the current frame completes with tlst.
REQ-024 A stop in GAP SHALL move to IDLE the next cycle with done=1 and no further beats.
REQ-025 A stop in IDLE SHALL be ignored; start with stop in the same IDLE cycle: start SHALL be taken and stop SHALL be dropped.
REQ-026 A start while busy=1 SHALL be ignored (nfrm is not re-sampled).
REQ-027 FRM_LEN=1 SHALL give tlst=1 on every beat.
REQ-028 In continuous mode (nfrm=0), frame index and frm_cnt SHALL wrap 16'hFFFF -> 0 without stopping.

Reset
REQ-029 dat_resetn=0 SHALL immediately force IDLE and drive tvld, tlst, tdat, busy, done and frm_cnt to 0, and clear stop-pending.
REQ-030 A reset mid-frame SHALL abort with no tlst and no done; after release the block SHALL wait in IDLE for start.

Verification
REQ-031 Bench SHALL cover: FRM_LEN=4, GAP=0, nfrm=2, trdy=1 -> 8 consecutive beats, sample index 0,1,2,3,0,1,2,3, frame index 0x4 then 1x4, tlst on beats 4 and 8, done one cycle after beat 8, frm_cnt=2.
REQ-032 Bench SHALL cover: same setup with trdy toggling 1,0,0,1 repeating -> identical beat sequence, tdat/tlst stable during every stall, no beat lost or duplicated.
REQ-033 Bench SHALL cover: FRM_LEN=4, GAP=3, nfrm=2 -> exactly 3 cycles of tvld=0 between beat 4 and beat 5.
REQ-034 Bench SHALL cover: nfrm=0, stop pulsed at sample 1 of frame 5 -> frame 5 completes with tlst, done follows, frm_cnt=6.
REQ-035 Bench SHALL cover: dat_resetn low at sample 2 of frame 0 -> all outputs 0 asynchronously; after release with no start, tvld stays 0; a new start resumes at frame 0, sample 0.
REQ-036 Bench SHALL cover: start pulsed while busy, and start+stop together in IDLE -> the busy start is ignored, and the run starts with stop ignored.
